// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration scheduler: alternates one SISO between natural and
// interleaved half-iterations, streams block addresses, stops on limit/early-stop/watchdog.
module turbo_iter_ctrl #(
  parameter int BLK_LEN = 16,
  parameter int ADDR_W  = 4,
  parameter int ITER_W  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ITER_W-1:0] i_max_iter,
  input  logic              i_early_stop,
  input  logic              i_siso_done,
  output logic              o_siso_start,
  output logic              o_half,
  output logic              o_rd_valid,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_busy,
  output logic [ITER_W-1:0] o_iter,
  output logic              o_done,
  output logic              o_err
);

  // state | meaning
  // IDLE  | waiting for host start
  // FEED  | SISO started, streaming BLK_LEN read addresses
  // WAIT  | waiting for SISO done, watchdog running
  // CHECK | full iteration finished, decide stop or continue
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_FEED, S_WAIT, S_CHECK, S_DONE} state_t;

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLK_LEN - 1);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

  state_t            state_q;
  logic [ITER_W-1:0] limit_q;
  logic [ITER_W-1:0] iter_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WD_W-1:0]   wd_q;
  logic              half_q;
  logic              start_q;
  logic              valid_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      limit_q <= '0;
      iter_q  <= '0;
      addr_q  <= '0;
      wd_q    <= '0;
      half_q  <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            iter_q <= '0;
            err_q  <= 1'b0;
            half_q <= 1'b0;
            if (i_max_iter != '0) begin
              limit_q <= i_max_iter;
              busy_q  <= 1'b1;
              start_q <= 1'b1;
              valid_q <= 1'b1;
              addr_q  <= '0;
              state_q <= S_FEED;
            end else begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_FEED: begin
          if (addr_q == LAST_ADDR) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            state_q <= S_WAIT;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        S_WAIT: begin
          // done is checked first so a done on the last watchdog cycle wins
          if (i_siso_done) begin
            if (!half_q) begin
              half_q  <= 1'b1;
              start_q <= 1'b1;
              valid_q <= 1'b1;
              addr_q  <= '0;
              state_q <= S_FEED;
            end else begin
              iter_q  <= iter_q + ITER_W'(1);
              state_q <= S_CHECK;
            end
          end else if (wd_q == WD_LAST) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            wd_q <= wd_q + WD_W'(1);
          end
        end
        S_CHECK: begin
          if (iter_q == limit_q || i_early_stop) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            half_q  <= 1'b0;
            start_q <= 1'b1;
            valid_q <= 1'b1;
            addr_q  <= '0;
            state_q <= S_FEED;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_siso_start = start_q;
  assign o_half       = half_q;
  assign o_rd_valid   = valid_q;
  assign o_rd_addr    = addr_q;
  assign o_busy       = busy_q;
  assign o_iter       = iter_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_turbo_iter_ctrl.sv
// Bench for turbo_iter_ctrl: table of decode scenarios, a model that queues the
// expected SISO start / address / completion events, and a negedge monitor.
module tb_turbo_iter_ctrl;
  localparam int BLK_LEN = 16;
  localparam int ADDR_W  = 4;
  localparam int ITER_W  = 4;
  localparam int TIMEOUT = 64;

  localparam logic [1:0] EV_START = 2'd0;
  localparam logic [1:0] EV_ADDR  = 2'd1;
  localparam logic [1:0] EV_DONE  = 2'd2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ITER_W-1:0] max_iter = '0;
  logic              early_stop = 1'b0;
  logic              siso_done = 1'b0;
  logic              siso_start, half, rd_valid, busy, done, err;
  logic [ADDR_W-1:0] rd_addr;
  logic [ITER_W-1:0] iter;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] val;
  } ev_t;

  typedef struct {
    int max_it;     // i_max_iter at start
    int done_wait;  // WAIT cycle (1-based) on which done is given, 0 = never
    int early_chk;  // iteration count at whose CHECK early_stop is raised, 0 = never
    int noise;      // spurious start/done pulses and max_iter change
    int exp_iter;
    int exp_err;
  } case_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  turbo_iter_ctrl #(.BLK_LEN(BLK_LEN), .ADDR_W(ADDR_W), .ITER_W(ITER_W), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_max_iter(max_iter),
    .i_early_stop(early_stop), .i_siso_done(siso_done),
    .o_siso_start(siso_start), .o_half(half), .o_rd_valid(rd_valid), .o_rd_addr(rd_addr),
    .o_busy(busy), .o_iter(iter), .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = 8'(v);
    exp_q.push_back(e);
  endtask

  task automatic observe(input logic [1:0] k, input int v, input string name);
    ev_t e;
    if (exp_q.size() == 0) begin
      check({name, " unexpected"}, v, -1);
    end else begin
      e = exp_q.pop_front();
      check({name, " kind"}, int'(k), int'(e.kind));
      check(name, v, int'(e.val));
    end
  endtask

  task automatic monitor();
    if (siso_start) observe(EV_START, int'(half), "siso_start half");
    if (rd_valid)   observe(EV_ADDR, int'(rd_addr), "rd_addr");
    if (done)       observe(EV_DONE, {busy, err, iter}, "done {busy,err,iter}");
  endtask

  // Reference model of the whole decode as an event list.
  task automatic model(input case_t c);
    int it = 0;
    if (c.max_it == 0) begin
      push(EV_DONE, 0);
      return;
    end
    forever begin
      for (int h = 0; h < 2; h++) begin
        push(EV_START, h);
        for (int a = 0; a < BLK_LEN; a++) push(EV_ADDR, a);
        if (c.done_wait == 0 || c.done_wait > TIMEOUT) begin
          push(EV_DONE, {1'b0, 1'b1, 4'(it)});
          return;
        end
      end
      it++;
      if (it == c.max_it || it == c.early_chk) begin
        push(EV_DONE, {1'b0, 1'b0, 4'(it)});
        return;
      end
    end
  endtask

  task automatic run_case(input case_t c, input string tag);
    int  cyc = 0, wcnt = 0, halves = 0, iters = 0;
    bit  in_wait = 0, prev_valid = 0, chk_pending = 0, seen_done = 0;
    model(c);
    @(negedge clk);
    start    = 1'b1;
    max_iter = ITER_W'(c.max_it);
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start      = 1'b0;
      siso_done  = 1'b0;
      early_stop = 1'b0;
      monitor();
      if (chk_pending) begin
        early_stop  = (iters == c.early_chk);
        chk_pending = 0;
      end
      if (rd_valid) begin
        in_wait = 0;
        if (c.noise != 0 && rd_addr == 4'd0) max_iter = '0;
        if (c.noise != 0 && rd_addr == 4'd5) begin
          start     = 1'b1;
          siso_done = 1'b1;
        end
      end else if (busy && prev_valid) begin
        in_wait = 1;
        wcnt    = 1;
      end else if (in_wait) begin
        wcnt++;
      end
      if (in_wait && busy) begin
        if (c.noise != 0 && wcnt == 1) start = 1'b1;
        if (wcnt == c.done_wait) begin
          siso_done = 1'b1;
          in_wait   = 0;
          halves++;
          if (halves % 2 == 0) begin
            iters++;
            chk_pending = 1;
          end
        end
      end
      if (done) begin
        seen_done = 1;
        if (c.noise != 0) start = 1'b1;
        if (c.exp_err != 0) check({tag, " watchdog cycles to done"}, wcnt, TIMEOUT + 1);
        if (c.max_it == 0) check({tag, " zero-limit done latency ok"}, int'(cyc <= 2), 1);
      end
      prev_valid = rd_valid;
    end
    if (!seen_done) check({tag, " done timeout"}, 0, 1);
    repeat (4) begin
      @(negedge clk);
      start     = 1'b0;
      siso_done = 1'b0;
      monitor();
    end
    check({tag, " final iter"}, int'(iter), c.exp_iter);
    check({tag, " final err"}, int'(err), c.exp_err);
    check({tag, " final busy"}, int'(busy), 0);
    check({tag, " leftover events"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  case_t cases[7];

  initial begin
    cases[0] = '{max_it: 2, done_wait: 3,  early_chk: 0, noise: 0, exp_iter: 2, exp_err: 0};
    cases[1] = '{max_it: 8, done_wait: 3,  early_chk: 1, noise: 0, exp_iter: 1, exp_err: 0};
    cases[2] = '{max_it: 3, done_wait: 0,  early_chk: 0, noise: 0, exp_iter: 0, exp_err: 1};
    cases[3] = '{max_it: 1, done_wait: 64, early_chk: 0, noise: 0, exp_iter: 1, exp_err: 0};
    cases[4] = '{max_it: 0, done_wait: 3,  early_chk: 0, noise: 0, exp_iter: 0, exp_err: 0};
    cases[5] = '{max_it: 2, done_wait: 1,  early_chk: 0, noise: 1, exp_iter: 2, exp_err: 0};
    cases[6] = '{max_it: 3, done_wait: 2,  early_chk: 2, noise: 0, exp_iter: 2, exp_err: 0};

    repeat (3) @(negedge clk);
    check("reset outputs", int'({siso_start, half, rd_valid, rd_addr, busy, iter, done, err}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (cases[i]) run_case(cases[i], $sformatf("case%0d", i));

    // Reset during FEED at address 7 aborts without a done pulse.
    @(negedge clk);
    start    = 1'b1;
    max_iter = 4'd2;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 40 && !(rd_valid && rd_addr == 4'd7); k++) @(negedge clk);
    check("reached addr 7", int'(rd_addr), 7);
    rst_n = 1'b0;
    #1;
    check("outputs after async reset",
          int'({siso_start, half, rd_valid, rd_addr, busy, iter, done, err}), 0);
    repeat (3) begin
      @(negedge clk);
      check("no done while in reset", int'(done), 0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle after reset release", int'({busy, done, rd_valid}), 0);
    end
    run_case(cases[0], "post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
